// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle instruction sequencer for the MIPS datapath
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the
// datapath strobes and mux selects for the current state. Waits on mem_ready in
// the memory states, traps on illegal opcodes or memory timeout, and counts
// retired instructions.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   OpCode, Zero          opcode field and ALU zero flag from the datapath
//   mem_ready             memory finished the current access this cycle
//   PCWrite .. ALUOp      datapath strobes and mux selects
//   trap, trap_cause      sticky trap flag and cause (1 illegal op, 2 mem timeout)
//   instr_count           retired instruction count, wraps
module mips_multicycle_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [3:0]       ALUOp,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, TRAP
    } stateT;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    stateT      state;
    stateT      nextState;
    logic [7:0] waitCnt;
    logic       waitState;
    logic       timeout;
    logic       retire;
    logic [1:0] trapCauseNext;

    assign waitState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A ready on the last allowed cycle takes priority over the timeout.
    assign timeout   = waitState && !mem_ready && (waitCnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            waitCnt     <= 8'd0;
            instr_count <= '0;
            trap        <= 1'b0;
            trap_cause  <= 2'd0;
        end else begin
            state <= nextState;
            if (nextState == TRAP && state != TRAP) begin
                trap       <= 1'b1;
                trap_cause <= trapCauseNext;
            end
            // Counter only survives while we keep waiting in the same state.
            if (waitState && nextState == state) begin
                waitCnt <= waitCnt + 8'd1;
            end else begin
                waitCnt <= 8'd0;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nextState     = state;
        retire        = 1'b0;
        trapCauseNext = 2'd0;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'd0;
        PCSource      = 2'd0;
        ALUOp         = ALU_ADD;

        if (timeout) begin
            trapCauseNext = 2'd2;
        end

        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                if (mem_ready)    nextState = DECODE;
                else if (timeout) nextState = TRAP;
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                case (OpCode)
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_R:         nextState = R_EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDI_EXEC;
                    default: begin
                        nextState     = TRAP;
                        trapCauseNext = 2'd1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                nextState = (OpCode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)    nextState = MEM_WB;
                else if (timeout) nextState = TRAP;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                nextState = FETCH;
                retire    = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    nextState = FETCH;
                    retire    = 1'b1;
                end else if (timeout) begin
                    nextState = TRAP;
                end
            end
            R_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_FUNCT;
                nextState = R_WB;
            end
            R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                nextState = FETCH;
                retire    = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_SUB;
                PCSource  = 2'd1;
                PCWrite   = Zero;
                nextState = FETCH;
                retire    = 1'b1;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'd2;
                nextState = FETCH;
                retire    = 1'b1;
            end
            ADDI_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                nextState = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
                retire    = 1'b1;
            end
            TRAP: begin
                nextState = TRAP;
            end
            default: begin
                nextState = FETCH;
            end
        endcase

        // Reset may arrive mid-instruction; no write or read may leak out while it is held.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5;
    localparam int S_REXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9, S_AEXEC = 10, S_AWB = 11, S_TRAP = 12;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, trap_cause;
    logic [3:0] ALUOp;
    logic       trap;
    logic [3:0] instr_count;

    logic [16:0] expQ[$];
    logic [16:0] e;
    logic [3:0]  cntModel = 4'd0;
    int          nTests = 0;
    int          nFail = 0;

    wire [16:0] outVec = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst,
                          RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    mips_multicycle_ctrl #(.WAIT_MAX(16), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] expOut(int st, logic mr, logic z);
        logic pcw = 0, irw = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, rdst = 0, rw = 0, srca = 0;
        logic [1:0] srcb = 0, pcs = 0;
        logic [3:0] aop = 0;
        case (st)
            S_FETCH:  begin mrd = 1; srcb = 1; pcw = mr; irw = mr; end
            S_DECODE: begin srcb = 3; end
            S_MADDR:  begin srca = 1; srcb = 2; end
            S_MRD:    begin mrd = 1; iord = 1; end
            S_MWB:    begin rw = 1; m2r = 1; end
            S_MWR:    begin mwr = 1; iord = 1; end
            S_REXEC:  begin srca = 1; aop = 4'b0010; end
            S_RWB:    begin rw = 1; rdst = 1; end
            S_BRANCH: begin srca = 1; aop = 4'b0001; pcs = 1; pcw = z; end
            S_JUMP:   begin pcw = 1; pcs = 2; end
            S_AEXEC:  begin srca = 1; srcb = 2; end
            S_AWB:    begin rw = 1; end
            default:  ;
        endcase
        return {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, srca, srcb, pcs, aop};
    endfunction

    task automatic drive(int st, logic mr, logic z);
        mem_ready = mr;
        Zero      = z;
        expQ.push_back(expOut(st, mr, z));
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        cntModel = 4'd0;
        expQ.delete();
    endtask

    task automatic test_reset();
        int js[3] = '{S_FETCH, S_DECODE, S_JUMP};
        reset = 1'b1; mem_ready = 1'b1; OpCode = OP_J;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nTests++;
            if ({PCWrite, IRWrite, RegWrite, MemWrite, MemRead} !== 5'b0) begin
                nFail++; $display("FAIL reset_strobes cyc%0d: got %b want 00000", i, {PCWrite, IRWrite, RegWrite, MemWrite, MemRead});
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; cntModel = 4'd0;
        nTests++;
        if (instr_count !== 4'd0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
            nFail++; $display("FAIL reset_state: got cnt=%0d trap=%b cause=%0d want 0/0/0", instr_count, trap, trap_cause);
        end
        for (int i = 0; i < 3; i++) begin
            drive(js[i], 1'b1, 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL reset_then_j cyc%0d: got %h want %h", i, outVec, e); end
            @(posedge clk); #1;
        end
        cntModel++;
        nTests++;
        if (instr_count !== cntModel) begin nFail++; $display("FAIL reset_then_j_count: got %0d want %0d", instr_count, cntModel); end
    endtask

    task automatic test_lw();
        int sts[5] = '{S_FETCH, S_DECODE, S_MADDR, S_MRD, S_MWB};
        OpCode = OP_LW;
        for (int i = 0; i < 5; i++) begin
            drive(sts[i], 1'b1, 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL lw cyc%0d: got %h want %h", i, outVec, e); end
            @(posedge clk); #1;
        end
        cntModel++;
        nTests++;
        if (instr_count !== cntModel) begin nFail++; $display("FAIL lw_count: got %0d want %0d", instr_count, cntModel); end
    endtask

    task automatic test_r_addi();
        int rs[4] = '{S_FETCH, S_DECODE, S_REXEC, S_RWB};
        int as[4] = '{S_FETCH, S_DECODE, S_AEXEC, S_AWB};
        for (int k = 0; k < 2; k++) begin
            OpCode = (k == 0) ? OP_R : OP_ADDI;
            for (int i = 0; i < 4; i++) begin
                drive((k == 0) ? rs[i] : as[i], 1'b1, 1'b0);
                @(negedge clk); e = expQ.pop_front(); nTests++;
                if (outVec !== e) begin nFail++; $display("FAIL r_addi%0d cyc%0d: got %h want %h", k, i, outVec, e); end
                @(posedge clk); #1;
            end
            cntModel++;
            nTests++;
            if (instr_count !== cntModel) begin nFail++; $display("FAIL r_addi%0d_count: got %0d want %0d", k, instr_count, cntModel); end
        end
    endtask

    task automatic test_beq();
        int bs[3] = '{S_FETCH, S_DECODE, S_BRANCH};
        OpCode = OP_BEQ;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                drive(bs[i], 1'b1, (k == 0));
                @(negedge clk); e = expQ.pop_front(); nTests++;
                if (outVec !== e) begin nFail++; $display("FAIL beq_z%0d cyc%0d: got %h want %h", (k == 0), i, outVec, e); end
                @(posedge clk); #1;
            end
            cntModel++;
            nTests++;
            if (instr_count !== cntModel) begin nFail++; $display("FAIL beq_count: got %0d want %0d", instr_count, cntModel); end
        end
        Zero = 1'b0;
    endtask

    task automatic test_sw_wait();
        int   sts[7] = '{S_FETCH, S_DECODE, S_MADDR, S_MWR, S_MWR, S_MWR, S_MWR};
        logic mrs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        OpCode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            drive(sts[i], mrs[i], 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL sw_wait cyc%0d: got %h want %h", i, outVec, e); end
            @(posedge clk); #1;
        end
        cntModel++;
        nTests++;
        if (instr_count !== cntModel || trap !== 1'b0) begin
            nFail++; $display("FAIL sw_wait_end: got cnt=%0d trap=%b want %0d/0", instr_count, trap, cntModel);
        end
    endtask

    task automatic test_illegal();
        int js[3] = '{S_FETCH, S_DECODE, S_JUMP};
        OpCode = 6'b111111;
        for (int i = 0; i < 22; i++) begin
            drive((i == 0) ? S_FETCH : (i == 1) ? S_DECODE : S_TRAP, 1'b1, 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL illegal_out cyc%0d: got %h want %h", i, outVec, e); end
            if (i >= 2) begin
                nTests++;
                if (trap !== 1'b1 || trap_cause !== 2'd1) begin
                    nFail++; $display("FAIL illegal_trap cyc%0d: got trap=%b cause=%0d want 1/1", i, trap, trap_cause);
                end
            end
            @(posedge clk); #1;
        end
        applyReset();
        nTests++;
        if (trap !== 1'b0 || trap_cause !== 2'd0 || instr_count !== 4'd0) begin
            nFail++; $display("FAIL illegal_recover: got trap=%b cause=%0d cnt=%0d want 0/0/0", trap, trap_cause, instr_count);
        end
        OpCode = OP_J;
        for (int i = 0; i < 3; i++) begin
            drive(js[i], 1'b1, 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL illegal_recover_j cyc%0d: got %h want %h", i, outVec, e); end
            @(posedge clk); #1;
        end
        cntModel++;
    endtask

    task automatic test_fetch_timeout();
        OpCode = OP_J;
        for (int i = 0; i < 17; i++) begin
            drive((i < 16) ? S_FETCH : S_TRAP, 1'b0, 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL timeout_out cyc%0d: got %h want %h", i, outVec, e); end
            nTests++;
            if (i < 16 && trap !== 1'b0) begin nFail++; $display("FAIL timeout_early cyc%0d: got trap=%b want 0", i, trap); end
            if (i == 16 && (trap !== 1'b1 || trap_cause !== 2'd2)) begin
                nFail++; $display("FAIL timeout_trap: got trap=%b cause=%0d want 1/2", trap, trap_cause);
            end
            @(posedge clk); #1;
        end
        applyReset();
    endtask

    task automatic test_fetch_late_ready();
        OpCode = OP_J;
        for (int i = 0; i < 18; i++) begin
            drive((i < 16) ? S_FETCH : (i == 16) ? S_DECODE : S_JUMP, (i >= 15), 1'b0);
            @(negedge clk); e = expQ.pop_front(); nTests++;
            if (outVec !== e) begin nFail++; $display("FAIL late_ready cyc%0d: got %h want %h", i, outVec, e); end
            @(posedge clk); #1;
        end
        cntModel++;
        nTests++;
        if (trap !== 1'b0 || instr_count !== cntModel) begin
            nFail++; $display("FAIL late_ready_end: got trap=%b cnt=%0d want 0/%0d", trap, instr_count, cntModel);
        end
    endtask

    task automatic test_count_wrap();
        int js[3] = '{S_FETCH, S_DECODE, S_JUMP};
        applyReset();
        OpCode = OP_J;
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 3; i++) begin
                drive(js[i], 1'b1, 1'b0);
                @(negedge clk); e = expQ.pop_front(); nTests++;
                if (outVec !== e) begin nFail++; $display("FAIL wrap_j%0d cyc%0d: got %h want %h", j, i, outVec, e); end
                @(posedge clk); #1;
            end
            cntModel++;
            nTests++;
            if (instr_count !== cntModel) begin nFail++; $display("FAIL wrap_count j%0d: got %0d want %0d", j, instr_count, cntModel); end
        end
        nTests++;
        if (instr_count !== 4'd0) begin nFail++; $display("FAIL wrap_zero: got %0d want 0", instr_count); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_addi();
        test_beq();
        test_sw_wait();
        test_illegal();
        test_fetch_timeout();
        test_fetch_late_ready();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
